// File: rtl/lcd_pattern_sequencer.sv
// Purpose : LCD timing generator plus test-pattern source with a frame-synchronous pattern scheduler.
// Latency : every LCD output and the frame_start/pat_ack pulses are registered, 1 cycle behind the counters.
// Backpr. : none; the raster is free-running and pattern requests are never stalled (last request wins).
//
// Ports:
//   PixelClk, nRST          pixel clock, asynchronous active-low reset
//   auto_en                 step through the patterns every FRAMES_PER_PAT frames
//   pat_req, pat_sel[1:0]   pattern-change request, applied at the next frame boundary
//   pat_ack                 1-cycle pulse when a request has been applied
//   cur_pat[1:0]            active pattern (0 white, 1 bars, 2 grid, 3 gradient)
//   frame_start             1-cycle pulse aligned with the first output cycle of a frame
//   LCD_DE/HSYNC/VSYNC, LCD_R/G/B   panel interface (syncs active-low)
module lcd_pattern_sequencer #(
    parameter int H_ACTIVE       = 800,
    parameter int H_BP           = 182,
    parameter int H_FP           = 210,
    parameter int H_PULSE        = 1,
    parameter int V_ACTIVE       = 480,
    parameter int V_BP           = 6,
    parameter int V_FP           = 62,
    parameter int V_PULSE        = 5,
    parameter int FRAMES_PER_PAT = 60
) (
    input  logic       PixelClk,
    input  logic       nRST,
    input  logic       auto_en,
    input  logic       pat_req,
    input  logic [1:0] pat_sel,
    output logic       pat_ack,
    output logic [1:0] cur_pat,
    output logic       frame_start,
    output logic       LCD_DE,
    output logic       LCD_HSYNC,
    output logic       LCD_VSYNC,
    output logic [4:0] LCD_R,
    output logic [5:0] LCD_G,
    output logic [4:0] LCD_B
);

    localparam int H_TOTAL = H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_BP + V_ACTIVE + V_FP;
    // Counters are at least as wide as the pixel coordinates derived from them.
    localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
    localparam int VW = ($clog2(V_TOTAL) > 9) ? $clog2(V_TOTAL) : 9;
    localparam int FW = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;

    localparam logic [1:0] PAT_WHITE = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_GRID  = 2'd2;
    localparam logic [1:0] PAT_GRAD  = 2'd3;

    // Raster counters
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    // Scheduler
    logic [1:0]    state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          pend_q, pend_d;
    logic [1:0]    pend_sel_q, pend_sel_d;
    logic          run_q;
    logic          ack_d;

    // Registered outputs
    logic       ack_q, fs_q, de_q, hs_q, vs_q;
    logic [4:0] r_q, b_q;
    logic [5:0] g_q;

    // Combinational raster decode
    logic       h_last, v_last, boundary;
    logic       de_c, hs_c, vs_c;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [4:0] pix_r, pix_b;
    logic [5:0] pix_g;
    logic [2:0] bar;

    always_comb begin
        h_last   = (h_cnt_q == HW'(H_TOTAL - 1));
        v_last   = (v_cnt_q == VW'(V_TOTAL - 1));
        boundary = (h_cnt_q == '0) && (v_cnt_q == '0);

        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end

        hs_c = (h_cnt_q >= HW'(H_PULSE));
        vs_c = (v_cnt_q >= VW'(V_PULSE));
        de_c = (h_cnt_q >= HW'(H_BP)) && (h_cnt_q < HW'(H_BP + H_ACTIVE)) &&
               (v_cnt_q >= VW'(V_BP)) && (v_cnt_q < VW'(V_BP + V_ACTIVE));

        // Coordinates wrap outside the active area; they are only used while de_c is high.
        pix_x = 10'(h_cnt_q - HW'(H_BP));
        pix_y = 9'(v_cnt_q - VW'(V_BP));
    end

    // Pattern generator
    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        bar   = '0;
        for (int i = 1; i < 8; i++) begin
            if (pix_x >= 10'(100 * i)) bar = 3'(i);
        end
        case (state_q)
            PAT_WHITE: begin
                pix_r = 5'd31;
                pix_g = 6'd63;
                pix_b = 5'd31;
            end
            PAT_BARS: begin
                // Bar order W,Y,C,G,M,R,B,K: each channel is a single inverted index bit.
                pix_r = {5{~bar[1]}};
                pix_g = {6{~bar[2]}};
                pix_b = {5{~bar[0]}};
            end
            PAT_GRID: begin
                if ((pix_x[4:0] == 5'd0) || (pix_y[4:0] == 5'd0)) begin
                    pix_r = 5'd31;
                    pix_g = 6'd63;
                    pix_b = 5'd31;
                end
            end
            default: begin
                pix_r = pix_x[9:5];
                pix_g = pix_y[8:3];
                pix_b = 5'd31 - pix_x[9:5];
            end
        endcase
    end

    // Scheduler next state. The boundary seen right after reset opens the first frame
    // rather than closing one, so run_q keeps it from counting towards auto-advance.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        ack_d      = 1'b0;

        if (boundary && run_q) begin
            if (pend_q) begin
                state_d = pend_sel_q;
                pend_d  = 1'b0;
                fcnt_d  = '0;
                ack_d   = 1'b1;
            end else if (auto_en) begin
                if (fcnt_q == FW'(FRAMES_PER_PAT - 1)) begin
                    fcnt_d = '0;
                    case (state_q)
                        PAT_WHITE: state_d = PAT_BARS;
                        PAT_BARS:  state_d = PAT_GRID;
                        PAT_GRID:  state_d = PAT_GRAD;
                        default:   state_d = PAT_WHITE;
                    endcase
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end

        if (!auto_en) begin
            fcnt_d = '0;
        end

        // Evaluated after the boundary consumption so a request on the boundary cycle
        // stays pending for the following frame.
        if (pat_req) begin
            pend_d     = 1'b1;
            pend_sel_d = pat_sel;
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            state_q    <= PAT_WHITE;
            fcnt_q     <= '0;
            pend_q     <= 1'b0;
            pend_sel_q <= 2'd0;
            run_q      <= 1'b0;
            ack_q      <= 1'b0;
            fs_q       <= 1'b0;
            de_q       <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            run_q      <= 1'b1;
            ack_q      <= ack_d;
            fs_q       <= boundary;
            de_q       <= de_c;
            hs_q       <= hs_c;
            vs_q       <= vs_c;
            r_q        <= de_c ? pix_r : 5'd0;
            g_q        <= de_c ? pix_g : 6'd0;
            b_q        <= de_c ? pix_b : 5'd0;
        end
    end

    assign pat_ack     = ack_q;
    assign cur_pat     = state_q;
    assign frame_start = fs_q;
    assign LCD_DE      = de_q;
    assign LCD_HSYNC   = hs_q;
    assign LCD_VSYNC   = vs_q;
    assign LCD_R       = r_q;
    assign LCD_G       = g_q;
    assign LCD_B       = b_q;

endmodule

// File: tb/tb_lcd_pattern_sequencer.sv
// Purpose : scoreboard bench for lcd_pattern_sequencer with a shrunk raster (808 x 4, 3232 cycles/frame).
// Latency : expected per-frame records are queued ahead of each frame and popped on frame_start.
// Backpr. : none; the monitor samples every negedge.
module tb_lcd_pattern_sequencer;

    // Raster: H 4+800+4 (pulse 2), V 1+2+1 (pulse 1), two frames per auto pattern.
    localparam int T_FRAME   = 3232;   // 808 * 4
    localparam int EXP_DE    = 1600;   // 800 * 2
    localparam int EXP_HS    = 8;      // 2 cycles * 4 lines
    localparam int EXP_VS    = 808;    // 1 line
    localparam int EXP_FIRST = 812;    // 1 line + 4 back-porch cycles after frame_start

    typedef struct packed {
        logic [1:0] pat;
        logic       ack;
    } frame_t;

    logic       PixelClk = 1'b0;
    logic       nRST     = 1'b1;
    logic       auto_en  = 1'b0;
    logic       pat_req  = 1'b0;
    logic [1:0] pat_sel  = 2'd0;
    logic       pat_ack, frame_start, LCD_DE, LCD_HSYNC, LCD_VSYNC;
    logic [1:0] cur_pat;
    logic [4:0] LCD_R, LCD_B;
    logic [5:0] LCD_G;

    int     n_vec = 0;
    int     n_err = 0;
    frame_t exp_q[$];
    int     samp[14] = '{0, 31, 32, 99, 100, 150, 199, 200, 350, 450, 550, 650, 750, 799};

    lcd_pattern_sequencer #(
        .H_ACTIVE(800), .H_BP(4), .H_FP(4), .H_PULSE(2),
        .V_ACTIVE(2), .V_BP(1), .V_FP(1), .V_PULSE(1),
        .FRAMES_PER_PAT(2)
    ) dut (
        .PixelClk(PixelClk), .nRST(nRST), .auto_en(auto_en),
        .pat_req(pat_req), .pat_sel(pat_sel), .pat_ack(pat_ack),
        .cur_pat(cur_pat), .frame_start(frame_start),
        .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
        .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B)
    );

    always #5 PixelClk = ~PixelClk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_sample(input int x);
        foreach (samp[i]) if (samp[i] == x) return 1'b1;
        return 1'b0;
    endfunction

    // Expected {R,G,B} for a visible pixel.
    function automatic int pix_model(input logic [1:0] p, input int x, input int y);
        int r, g, b;
        r = 0; g = 0; b = 0;
        case (p)
            2'd0: begin r = 31; g = 63; b = 31; end
            2'd1: case (x / 100)
                    0: begin r = 31; g = 63; b = 31; end
                    1: begin r = 31; g = 63; b = 0;  end
                    2: begin r = 0;  g = 63; b = 31; end
                    3: begin r = 0;  g = 63; b = 0;  end
                    4: begin r = 31; g = 0;  b = 31; end
                    5: begin r = 31; g = 0;  b = 0;  end
                    6: begin r = 0;  g = 0;  b = 31; end
                    default: begin r = 0; g = 0; b = 0; end
                  endcase
            2'd2: if ((x % 32 == 0) || (y % 32 == 0)) begin r = 31; g = 63; b = 31; end
            default: begin r = x / 32; g = y / 8; b = 31 - x / 32; end
        endcase
        return (r << 11) | (g << 5) | b;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        int     cyc, de_cnt, hs, vs, first_de, blank_bad, stray, px, line;
        bit     in_frame, prev_de, have_rec;
        frame_t rec;
        in_frame = 0; prev_de = 0; have_rec = 0;
        cyc = 0; de_cnt = 0; hs = 0; vs = 0; first_de = -1; blank_bad = 0; stray = 0; px = 0; line = -1;
        rec = '0;
        forever begin
            @(negedge PixelClk);
            if (!nRST) begin
                in_frame = 0;
                prev_de  = 0;
            end else begin
                if (frame_start) begin
                    if (in_frame) begin
                        check("frame_period", cyc, T_FRAME);
                        check("de_cycles", de_cnt, EXP_DE);
                        check("hsync_low_cycles", hs, EXP_HS);
                        check("vsync_low_cycles", vs, EXP_VS);
                        check("first_de_offset", first_de, EXP_FIRST);
                        check("rgb_nonzero_while_blank", blank_bad, 0);
                        check("stray_pat_ack", stray, 0);
                    end
                    check("expected_frame_available", int'(exp_q.size() != 0), 1);
                    have_rec = (exp_q.size() != 0);
                    if (have_rec) begin
                        rec = exp_q.pop_front();
                        check("cur_pat", int'(cur_pat), int'(rec.pat));
                        check("pat_ack", int'(pat_ack), int'(rec.ack));
                    end
                    in_frame = 1;
                    cyc = 0; de_cnt = 0; hs = 0; vs = 0; first_de = -1;
                    blank_bad = 0; stray = 0; px = 0; line = -1;
                end else if (pat_ack) begin
                    stray++;
                end
                if (in_frame) begin
                    if (LCD_DE) begin
                        if (!prev_de) begin
                            line++;
                            px = 0;
                            if (first_de < 0) first_de = cyc;
                        end else begin
                            px++;
                        end
                        de_cnt++;
                        if (have_rec && is_sample(px))
                            check($sformatf("pixel pat%0d x%0d y%0d", rec.pat, px, line),
                                  int'({LCD_R, LCD_G, LCD_B}), pix_model(rec.pat, px, line));
                    end else if ({LCD_R, LCD_G, LCD_B} != 16'd0) begin
                        blank_bad++;
                    end
                    if (!LCD_HSYNC) hs++;
                    if (!LCD_VSYNC) vs++;
                    cyc++;
                end
                prev_de = LCD_DE;
            end
        end
    end

    // Reset must force outputs without waiting for a clock edge.
    initial begin
        forever begin
            @(negedge nRST);
            #1;
            check("rst_de", int'(LCD_DE), 0);
            check("rst_hsync", int'(LCD_HSYNC), 1);
            check("rst_vsync", int'(LCD_VSYNC), 1);
            check("rst_rgb", int'({LCD_R, LCD_G, LCD_B}), 0);
            check("rst_pat_ack", int'(pat_ack), 0);
            check("rst_frame_start", int'(frame_start), 0);
            check("rst_cur_pat", int'(cur_pat), 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic skip(input int n);
        repeat (n) @(negedge PixelClk);
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge PixelClk);
            n++;
        end while (!frame_start && n < T_FRAME + 100);
        check({"frame_start_seen ", tag}, int'(frame_start), 1);
    endtask

    task automatic pulse_req(input logic [1:0] sel);
        pat_req = 1'b1;
        pat_sel = sel;
        @(negedge PixelClk);
        pat_req = 1'b0;
    endtask

    task automatic push(input logic [1:0] p, input logic a);
        frame_t f;
        f.pat = p;
        f.ack = a;
        exp_q.push_back(f);
    endtask

    initial begin
        #3 nRST = 1'b0;
        skip(3);
        push(2'd0, 1'b0);                     // F0: reset pattern, no ack
        nRST = 1'b1;
        wait_fs("F0");

        skip(200); pulse_req(2'd1);
        push(2'd1, 1'b1);                     // F1: request applied at boundary
        wait_fs("F1");

        skip(200); pulse_req(2'd2);
        skip(300); pulse_req(2'd3);
        push(2'd3, 1'b1);                     // F2: last request wins, single ack
        wait_fs("F2");

        push(2'd3, 1'b0);                     // F3: request on boundary cycle not yet applied
        push(2'd2, 1'b1);                     // F4: applied one frame later
        skip(T_FRAME - 1);
        pat_req = 1'b1;
        pat_sel = 2'd2;
        wait_fs("F3");
        pat_req = 1'b0;
        wait_fs("F4");

        skip(500); pulse_req(2'd2);
        push(2'd2, 1'b1);                     // F5: re-requesting active pattern still acks
        wait_fs("F5");

        // Mid-line reset (h_cnt ~ 500, DE active) with a request pending.
        skip(100); pulse_req(2'd1);
        skip(1206);
        #2 nRST = 1'b0;
        skip(3);
        auto_en = 1'b1;
        push(2'd0, 1'b0); push(2'd0, 1'b0);   // G0..G9: 0,0,1,1,2,2,3,3,0,0
        push(2'd1, 1'b0); push(2'd1, 1'b0);
        push(2'd2, 1'b0); push(2'd2, 1'b0);
        push(2'd3, 1'b0); push(2'd3, 1'b0);
        push(2'd0, 1'b0); push(2'd0, 1'b0);
        nRST = 1'b1;
        for (int i = 0; i < 10; i++) wait_fs($sformatf("G%0d", i));

        // Advance is due at the end of G9; the request must win and clear the counter.
        skip(300); pulse_req(2'd0);
        push(2'd0, 1'b1);                     // G10
        push(2'd0, 1'b0);                     // G11: counter restarted from 0
        push(2'd1, 1'b0);                     // G12
        wait_fs("G10");
        wait_fs("G11");
        wait_fs("G12");
        skip(5);
        check("leftover_expected_frames", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_pattern_sequencer.md
LCD_PATTERN_SEQUENCER -- requirements
Module: lcd_pattern_sequencer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: H_ACTIVE 800 visible pixels/line; H_BP 182 horizontal back porch; H_FP 210 horizontal front porch; H_PULSE 1 HSYNC width; V_ACTIVE 480 visible lines; V_BP 6 vertical back porch; V_FP 62 vertical front porch; V_PULSE 5 VSYNC width (lines); FRAMES_PER_PAT 60 frames per pattern in auto mode.
REQ-002 Ports (name, direction, width, meaning) SHALL be: PixelClk in 1 pixel clock; nRST in 1 asynchronous active-low reset; auto_en in 1 auto-cycle enable; pat_req in 1 pattern-change request; pat_sel in 2 requested pattern; pat_ack out 1 request-applied pulse; cur_pat out 2 active pattern; frame_start out 1 first-cycle-of-frame pulse; LCD_DE out 1; LCD_HSYNC out 1; LCD_VSYNC out 1; LCD_R out 5; LCD_G out 6; LCD_B out 5.
REQ-003 All logic SHALL be clocked by PixelClk, with reset nRST, asynchronous, active-low.

Function
REQ-004 H_TOTAL SHALL equal H_BP+H_ACTIVE+H_FP (1192) and V_TOTAL SHALL equal V_BP+V_ACTIVE+V_FP (548).
REQ-005 h_cnt SHALL count 0..H_TOTAL-1, wrap to 0, and on wrap increment v_cnt; v_cnt SHALL wrap from V_TOTAL-1 to 0.
REQ-006 HSYNC SHALL be low while h_cnt<H_PULSE and high otherwise; VSYNC SHALL be low while v_cnt<V_PULSE and high otherwise.
REQ-007 DE SHALL be high iff H_BP<=h_cnt<H_BP+H_ACTIVE and V_BP<=v_cnt<V_BP+V_ACTIVE.
REQ-008 Pixel coordinates SHALL be x=h_cnt-H_BP (10 bit) and y=v_cnt-V_BP (9 bit), and are only meaningful while DE is high.
REQ-009 All LCD outputs SHALL be registered with exactly 1 cycle latency from the counters, so that DE, syncs and RGB stay mutually aligned.
REQ-010 RGB SHALL be 0 whenever the registered DE is low.
REQ-011 Pattern 0 (white) SHALL output R=31, G=63, B=31.
REQ-012 Pattern 1 (colour bars) SHALL output 8 bars of 100 px, indexed by x/100, in the order white, yellow, cyan, green, magenta, red, blue, black, with every channel at either full scale or 0.
REQ-013 Pattern 2 (grid) SHALL output white when x[4:0]==0 or y[4:0]==0, and black otherwise.
REQ-014 Pattern 3 (gradient) SHALL output R=x[9:5], G=y[8:3], B=31-x[9:5], with all arithmetic truncated to channel width.
REQ-015 The pattern scheduler SHALL be an FSM with states PAT_WHITE, PAT_BARS, PAT_GRID, PAT_GRAD, and cur_pat SHALL equal the state encoding 0..3.
REQ-016 A pattern change SHALL take effect only at a frame boundary (h_cnt==0 and v_cnt==0); no pattern SHALL ever change mid-frame.
REQ-017 frame_start SHALL pulse high for 1 cycle when h_cnt==0 and v_cnt==0.
REQ-018 When pat_req is high, pat_sel SHALL be latched into a pending register and a pending flag SHALL be set.
REQ-019 A new pat_req while a request is pending SHALL overwrite the pending pattern (last request wins).
REQ-020 At the frame boundary with a request pending, the FSM SHALL enter the pending pattern, clear the pending flag, reset the frame counter to 0, and pulse pat_ack for 1 cycle.
REQ-021 A pat_req arriving on the boundary cycle itself SHALL be applied at the following frame boundary.
REQ-022 With auto_en=1 and no request pending, the frame counter SHALL increment at each boundary; when it reaches FRAMES_PER_PAT-1, the FSM SHALL advance in the order WHITE->BARS->GRID->GRAD->WHITE and the counter SHALL clear.
REQ-023 When a pending request and an auto-advance coincide at a boundary, the request SHALL win.
REQ-024 With auto_en=0, the frame counter SHALL hold at 0 and the pattern SHALL change only on request.
REQ-025 Requesting the currently active pattern SHALL still pulse pat_ack and reset the frame counter.

Reset
REQ-026 While nRST is low, h_cnt, v_cnt, the frame counter and the pending flag SHALL be 0; state SHALL be PAT_WHITE; LCD_DE=0, LCD_HSYNC=1, LCD_VSYNC=1, RGB=0, pat_ack=0, frame_start=0.
REQ-027 Reset asserted mid-frame SHALL abort immediately, discard any pending request, and restart timing from h_cnt=0, v_cnt=0 on release.

Verification
REQ-028 Release reset, run 2 frames -> HSYNC low for 1 cycle every 1192 cycles; VSYNC low for 5 lines every 548 lines; exactly 384000 DE cycles per frame.
REQ-029 auto_en=0, pattern 1 -> pixel x=150 gives R=31, G=63, B=0; x=750 gives 0,0,0; first DE cycle occurs 1 cycle after h_cnt==182 on v_cnt==6.
REQ-030 Issue pat_req with pat_sel=2 mid-frame, then pat_sel=3 before the boundary -> pat_ack pulses once at the boundary; cur_pat=3; pattern 3 is output for the entire next frame.
REQ-031 auto_en=1, FRAMES_PER_PAT=2 -> cur_pat sequence 0,0,1,1,2,2,3,3,0 across consecutive frames.
REQ-032 auto_en=1, pat_req with pat_sel=0 asserted in the frame where an auto-advance is due -> cur_pat=0, the frame counter clears, and pat_ack=1 for 1 cycle.
REQ-033 Assert nRST mid-line at h_cnt=500 with a request pending -> all outputs go to reset values asynchronously; after release, no pat_ack occurs and cur_pat=0.
